// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants used by the coefficient-normalisation stream.
package dilithium_pkg;

  localparam int DIL_N     = 256;
  localparam int DIL_LANES = 4;
  localparam int DIL_W     = 32;
  localparam int DIL_Q     = 8380417;

  // Per-polynomial processing mode, sampled on beat 0.
  localparam logic MODE_CADDQ  = 1'b0;
  localparam logic MODE_FREEZE = 1'b1;

endpackage

// File: rtl/poly_caddq_stream_reduce32.sv
// Combinational Dilithium reduce32 for one lane:
//   t = (a + 2^22) >>> 23 ; r = a - t*Q
// Computed one bit wider than the coefficient, then truncated. Outside the
// documented input range the result is unspecified but always fully defined.
module poly_caddq_stream_reduce32
  import dilithium_pkg::*;
#(
  parameter int W = DIL_W,
  parameter int Q = DIL_Q
) (
  input  logic [W-1:0] a_i,
  output logic [W-1:0] r_o
);

  localparam logic signed [W:0] ROUND_C = (W+1)'(64'sd4194304);
  localparam logic signed [W:0] Q_EXT_C = (W+1)'(Q);

  logic signed [W:0] a_ext_s;
  logic signed [W:0] sum_s;
  logic signed [W:0] t_s;

  // Rounded quotient estimate and subtraction of t*Q.
  always_comb begin
    a_ext_s = {a_i[W-1], a_i};
    sum_s   = a_ext_s + ROUND_C;
    t_s     = sum_s >>> 5'd23;
    r_o     = W'(a_ext_s - (t_s * Q_EXT_C));
  end

endmodule

// File: rtl/poly_caddq_stream.sv
// Streaming polynomial normaliser: LANES signed coefficients per beat.
// S1 optionally applies reduce32 (FREEZE polynomials), S2 applies caddq and
// drives the output port. Mode is captured on beat 0 and follows the
// polynomial's beats through the pipeline.
module poly_caddq_stream
  import dilithium_pkg::*;
#(
  parameter int N     = DIL_N,
  parameter int LANES = DIL_LANES,
  parameter int W     = DIL_W,
  parameter int Q     = DIL_Q
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic               out_last,
  output logic               busy
);

  localparam int BEATS = N / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);
  localparam logic [W-1:0]  Q_W      = W'(Q);

  logic               s1_valid_q, s1_valid_d;
  logic               s2_valid_q, s2_valid_d;
  logic [LANES*W-1:0] s1_data_q,  s1_data_d;
  logic [LANES*W-1:0] s2_data_q,  s2_data_d;
  logic [CW-1:0]      in_cnt_q,   in_cnt_d;
  logic [CW-1:0]      out_cnt_q,  out_cnt_d;
  logic               mode_q,     mode_d;

  logic               s1_adv_s;
  logic               s2_adv_s;
  logic               in_fire_s;
  logic               out_fire_s;
  logic               beat_mode_s;
  logic [LANES*W-1:0] red_s;
  logic [LANES*W-1:0] s1_in_s;
  logic [LANES*W-1:0] caddq_s;

  // Per-lane reduce32 on the incoming beat and caddq on the S1 contents.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    poly_caddq_stream_reduce32 #(.W(W), .Q(Q)) u_reduce32 (
      .a_i (in_data[W*k +: W]),
      .r_o (red_s[W*k +: W])
    );
    assign caddq_s[W*k +: W] =
      s1_data_q[W*k +: W] + (Q_W & {W{s1_data_q[W*k + W - 1]}});
  end

  // Handshake/stall terms and the effective mode of the beat on the input.
  always_comb begin
    s2_adv_s   = ~s2_valid_q | out_ready;
    s1_adv_s   = ~s1_valid_q | s2_adv_s;
    in_fire_s  = in_valid & s1_adv_s;
    out_fire_s = s2_valid_q & out_ready;
    if (in_cnt_q == CNT_ZERO) begin
      beat_mode_s = mode;
    end else begin
      beat_mode_s = mode_q;
    end
    if (beat_mode_s == MODE_FREEZE) begin
      s1_in_s = red_s;
    end else begin
      s1_in_s = in_data;
    end
  end

  // Next-state for both pipeline stages, beat counters and latched mode.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    mode_d     = mode_q;

    if (s1_adv_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = s1_in_s;
      end else begin
        s1_data_d = s1_data_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = caddq_s;
      end else begin
        s2_data_d = s2_data_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (in_fire_s) begin
      if (in_cnt_q == CNT_ZERO) begin
        mode_d = mode;
      end else begin
        mode_d = mode_q;
      end
      if (in_cnt_q == CNT_LAST) begin
        in_cnt_d = CNT_ZERO;
      end else begin
        in_cnt_d = in_cnt_q + CNT_ONE;
      end
    end else begin
      in_cnt_d = in_cnt_q;
    end

    if (out_fire_s) begin
      if (out_cnt_q == CNT_LAST) begin
        out_cnt_d = CNT_ZERO;
      end else begin
        out_cnt_d = out_cnt_q + CNT_ONE;
      end
    end else begin
      out_cnt_d = out_cnt_q;
    end
  end

  // State registers; reset discards any partially accepted polynomial.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_data_q  <= {(LANES*W){1'b0}};
      s2_data_q  <= {(LANES*W){1'b0}};
      in_cnt_q   <= CNT_ZERO;
      out_cnt_q  <= CNT_ZERO;
      mode_q     <= MODE_CADDQ;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_data_q  <= s1_data_d;
      s2_data_q  <= s2_data_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      mode_q     <= mode_d;
    end
  end

  assign in_ready  = s1_adv_s;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_last  = s2_valid_q & (out_cnt_q == CNT_LAST);
  assign busy      = (in_cnt_q != CNT_ZERO) | s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_poly_caddq_stream.sv
// Randomised bench for poly_caddq_stream with a scoreboard built from the
// plain-arithmetic definitions of reduce32 and caddq.
module tb_poly_caddq_stream;

  localparam int N     = 256;
  localparam int LANES = 4;
  localparam int W     = 32;
  localparam int Q     = 8380417;
  localparam int BEATS = N / LANES;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               mode;
  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*W-1:0] out_data;
  logic               out_last;
  logic               busy;

  poly_caddq_stream #(.N(N), .LANES(LANES), .W(W), .Q(Q)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Single comparison point: counts and reports.
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [127:0] exp_data_q[$];
  bit           exp_last_q[$];
  int           in_idx    = 0;
  bit           poly_mode = 1'b0;
  int           last_seen = 0;
  int           acc_cnt   = 0;
  bit           rand_rdy  = 1'b0;

  function automatic logic [31:0] ref_coef(input logic [31:0] a, input bit frz);
    longint x, t, r;
    int     r32;
    x = longint'($signed(a));
    r = x;
    if (frz) begin
      t = x + 64'sd4194304;
      if (t >= 0) t = t / 64'sd8388608;
      else        t = -((-t + 64'sd8388607) / 64'sd8388608);
      r = x - t * longint'(Q);
    end
    r32 = int'(r[31:0]);
    if (r32 < 0) r32 = r32 + Q;
    return 32'(r32);
  endfunction

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] rnd_frz();
    logic [31:0] v;
    v = $urandom;
    if ($signed(v) > 32'sd2143289343) v = v - 32'd4194304;
    return v;
  endfunction

  // Scoreboard: inputs recorded and outputs compared away from the clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        logic [127:0] e;
        if (in_idx == 0) poly_mode = mode;
        for (int k = 0; k < LANES; k++) e[32*k +: 32] = ref_coef(in_data[32*k +: 32], poly_mode);
        exp_data_q.push_back(e);
        exp_last_q.push_back(in_idx == BEATS - 1);
        in_idx = (in_idx + 1) % BEATS;
        acc_cnt++;
      end
      if (out_valid) begin
        if (exp_data_q.size() == 0) begin
          check_eq("out_unexpected", 128'(out_valid), 128'd0);
        end else begin
          check_eq("out_data", out_data, exp_data_q[0]);
          check_eq("out_last", 128'(out_last), 128'(exp_last_q[0]));
          if (out_ready) begin
            void'(exp_data_q.pop_front());
            void'(exp_last_q.pop_front());
            if (out_last) last_seen++;
          end
        end
      end
    end
  end

  // Random downstream readiness when enabled.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic flush_model();
    exp_data_q.delete();
    exp_last_q.delete();
    in_idx = 0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic m);
    bit acc;
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    acc      = 1'b0;
    guard    = 0;
    while (!acc && guard < 2000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) check_eq("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_data_q.size() != 0 || busy) && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("drain_queue", 128'(exp_data_q.size()), 128'd0);
    check_eq("drain_busy", 128'(busy), 128'd0);
  endtask

  initial begin
    int lbase;
    int a0;
    rst_n     = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 128'd0;
    out_ready = 1'b1;
    #2;
    do_reset();

    // Reset state
    check_eq("rst_out_valid", 128'(out_valid), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_in_ready", 128'(in_ready), 128'd1);
    check_eq("rst_out_last", 128'(out_last), 128'd0);
    check_eq("rst_out_data", out_data, 128'd0);

    // 1: CADDQ directed beat and latency
    send_beat(pack4(-1, 0, -8380417, 8380416), 1'b0);
    in_valid = 1'b0;
    check_eq("t1_lat_early", 128'(out_valid), 128'd0);
    @(posedge clk);
    #1;
    check_eq("t1_lat", 128'(out_valid), 128'd1);
    check_eq("t1_data", out_data, pack4(8380416, 0, 0, 8380416));
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // 2: FREEZE directed beat
    send_beat(pack4(8380417, 16760839, -1, 4194304), 1'b1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t2_valid", 128'(out_valid), 128'd1);
    check_eq("t2_data", out_data, pack4(0, 5, 8380416, 4194304));
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // 3: two back-to-back ramp polynomials
    lbase = last_seen;
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < BEATS; b++)
        send_beat(pack4(4*b - 128, 4*b - 127, 4*b - 126, 4*b - 125), 1'b0);
    in_valid = 1'b0;
    drain();
    check_eq("t3_last_count", 128'(last_seen - lbase), 128'd2);

    // 4: backpressure then random readiness
    out_ready = 1'b0;
    a0 = acc_cnt;
    in_valid = 1'b1;
    in_data  = {rnd_frz(), rnd_frz(), rnd_frz(), rnd_frz()};
    mode     = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("t4_accepted", 128'(acc_cnt - a0), 128'd2);
    check_eq("t4_in_ready", 128'(in_ready), 128'd0);
    rand_rdy = 1'b1;
    for (int b = 2; b < BEATS; b++) begin
      send_beat({rnd_frz(), rnd_frz(), rnd_frz(), rnd_frz()}, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    // 5: mid-polynomial mode change ignored; next polynomial FREEZE
    lbase = last_seen;
    for (int b = 0; b < BEATS; b++)
      send_beat({$urandom, $urandom, $urandom, $urandom}, (b >= 10) ? 1'b1 : 1'b0);
    for (int b = 0; b < BEATS; b++)
      send_beat({rnd_frz(), rnd_frz(), rnd_frz(), rnd_frz()}, (b == 0) ? 1'b1 : 1'b0);
    in_valid = 1'b0;
    drain();
    check_eq("t5_last_count", 128'(last_seen - lbase), 128'd2);

    // 6: reset mid-polynomial
    for (int b = 0; b < 30; b++)
      send_beat({rnd_frz(), rnd_frz(), rnd_frz(), rnd_frz()}, 1'b1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    flush_model();
    #1;
    check_eq("t6_out_valid", 128'(out_valid), 128'd0);
    check_eq("t6_busy", 128'(busy), 128'd0);
    check_eq("t6_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    lbase = last_seen;
    for (int b = 0; b < BEATS; b++)
      send_beat({rnd_frz(), rnd_frz(), rnd_frz(), rnd_frz()}, 1'b1);
    in_valid = 1'b0;
    drain();
    check_eq("t6_last_count", 128'(last_seen - lbase), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/poly_caddq_stream.md
Name: poly_caddq_stream

Overview:
- Streaming, parametrised successor to the flat combinational polynomial conditional-add-q block.
- Accepts a Dilithium polynomial as LANES signed coefficients per beat over a valid/ready handshake and returns it normalised to [0, Q-1].
- Two modes: CADDQ (add Q to negatives) and FREEZE (reduce32, then caddq).
- Sits between the NTT/arithmetic datapath and the packing units; it replaces the 8192-bit flat bus with a narrow pipelined stream.

Parameters:
N, 256, coefficients per polynomial
LANES, 4, coefficients per beat; N mod LANES = 0
W, 32, coefficient width, signed two's complement
Q, 8380417, modulus
BEATS, N/LANES (derived localparam), beats per polynomial

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  1  0=CADDQ, 1=FREEZE; sampled on the first beat of each polynomial
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_data  in  LANES*W  lane k at bits [W*k+W-1 : W*k]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  LANES*W  normalised coefficients, same lane order
out_last  out  1  high with the final beat (BEATS-1) of each polynomial
busy  out  1  high while a polynomial is partially accepted or any pipeline stage is valid

Behaviour:
- Reset (async assert, sync release): all valids 0, in_beat_cnt=0, out_beat_cnt=0, latched mode=0, out_data=0, out_last=0, busy=0. in_ready=1 after reset.
- Pipeline: two register stages, S1 then S2; S2 drives the outputs.
  - S1 = reduce32 per lane when the beat's mode is FREEZE; otherwise pass-through.
  - S2 = caddq per lane: out = a + (Q & {W{a[W-1]}}).
- Latency: 2 cycles from input acceptance to out_valid with no backpressure. Throughput: 1 beat/cycle.
- Stall rules:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv (combinational path from out_ready is permitted)
- Holding: out_data, out_last and out_valid hold stable while out_valid & !out_ready. No beat is dropped or duplicated.
- reduce32: t = (a + 2^22) >>> 23 (arithmetic shift); r = a - t*Q, computed in W+1 bits and truncated to W. Valid for a in [-2^31, 2^31-2^22-1]; the result lies in [-6283009, 6283008]. Outside that range the result is unspecified, but no X is permitted.
- Mode handling:
  - mode is latched when a beat is accepted with in_beat_cnt==0.
  - The latched value travels with that polynomial's beats; mode changes mid-polynomial are ignored.
- Counters:
  - in_beat_cnt increments per accepted beat and wraps BEATS-1 -> 0.
  - out_beat_cnt increments per output handshake; out_last = out_valid & (out_beat_cnt==BEATS-1); wraps to 0.
  - Back-to-back polynomials with no gap are legal.
- Simultaneous accept and emit in one cycle: both counters update independently.
- Reset mid-polynomial discards all in-flight beats. The next accepted beat is beat 0 of a new polynomial.

Decomposition:
- Shared package dilithium_pkg: Q, N, W, and localparam MODE_CADDQ=0 / MODE_FREEZE=1.
- One natural sub-module: reduce32, combinational, one per lane in a generate loop.
- S2 instantiates the existing caddq per lane.

Test Plan:
1. CADDQ mode, lane values {-1, 0, -8380417, 8380416} -> {8380416, 0, 0, 8380416}; out_valid exactly 2 cycles after acceptance.
2. FREEZE mode, lane values {8380417, 16760839, -1, 4194304} -> {0, 5, 8380416, 4194304}.
3. Full polynomial (64 beats, LANES=4), ramp input with in_valid held high -> 64 outputs in order; out_last only on beat 63; two polynomials back-to-back -> out_last twice, counters wrap.
4. Backpressure: hold out_ready=0 -> after 2 accepted beats, in_ready=0 and out_data stays stable. Release with random out_ready toggling -> output sequence identical to input order, no loss.
5. Mode toggled from CADDQ to FREEZE at beat 10 -> the whole polynomial is processed as CADDQ. The next polynomial, with mode=1 at beat 0, is processed as FREEZE.
6. rst_n asserted at beat 30 -> out_valid=0 and busy=0 immediately. A new polynomial after release -> out_last on its beat 63.
